// File: rtl/ln_wdma.sv
// LN stage-2 write-back DMA: FIFO-buffered result beats drained as single-beat MCIF writes with
// CSR-derived addresses. Optional sticky overflow flag under `LN_WDMA_OVF_CHK_EN.
module ln_wdma #(
  parameter int unsigned DW         = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BYTES_BEAT = 32,
  parameter int unsigned CH_W       = 5,
  parameter int unsigned W_W        = 8,
  parameter int unsigned H_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CH_W-1:0]  CH_in_div_Tout,
  input  logic [H_W-1:0]   h_in,
  input  logic [W_W-1:0]   w_in,
  input  logic [31:0]      feature_out_base_addr,
  input  logic [25:0]      feature_out_surface_stride,
  input  logic [15:0]      feature_out_line_stride,
  input  logic [DW-1:0]    dat_in,
  input  logic             dat_in_vld,
  output logic             credit_vld,
  output logic             LN2mcif_wr_req_vld,
  input  logic             LN2mcif_wr_req_rdy,
  output logic [32+DW-1:0] LN2mcif_wr_req_pd,
  output logic             busy,
  output logic             done
`ifdef LN_WDMA_OVF_CHK_EN
  ,
  output logic             ovf_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [31:0] BB = BYTES_BEAT[31:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [CH_W-1:0] ch_q, c_q, c_d;
  logic [W_W-1:0]  w_q, wc_q, wc_d;
  logic [H_W-1:0]  h_q, hc_q, hc_d;
  logic [31:0]     sstr_q, lstr_q;
  logic [31:0]     addr_q, addr_d, col_q, col_d, row_q, row_d;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic            credit_q;

  logic run, start_ok, empty, full, push, pop;
  logic last_c, last_w, last_h, last_beat;

  assign run       = (state_q == RUN);
  assign start_ok  = start && (state_q == IDLE);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_FULL);
  assign pop       = LN2mcif_wr_req_vld && LN2mcif_wr_req_rdy;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push      = dat_in_vld && run && (!full || pop);
  assign last_c    = (c_q == ch_q - 1'b1);
  assign last_w    = (wc_q == w_q - 1'b1);
  assign last_h    = (hc_q == h_q - 1'b1);
  assign last_beat = last_c && last_w && last_h;
  assign credit_vld = credit_q;

  always_comb begin
    state_d            = state_q;
    busy               = (state_q != IDLE);
    done               = 1'b0;
    LN2mcif_wr_req_vld = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        LN2mcif_wr_req_vld = !empty;
        if (pop && last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign LN2mcif_wr_req_pd = LN2mcif_wr_req_vld ? {addr_q, mem_q[rp_q]} : '0;

  // row_q/col_q hold the h- and w-term partial sums so each wrap reloads without a multiplier.
  always_comb begin
    c_d    = c_q;
    wc_d   = wc_q;
    hc_d   = hc_q;
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (start_ok) begin
      c_d    = '0;
      wc_d   = '0;
      hc_d   = '0;
      addr_d = feature_out_base_addr;
      col_d  = feature_out_base_addr;
      row_d  = feature_out_base_addr;
    end else if (pop) begin
      if (!last_c) begin
        c_d    = c_q + 1'b1;
        addr_d = addr_q + sstr_q;
      end else begin
        c_d = '0;
        if (!last_w) begin
          wc_d   = wc_q + 1'b1;
          col_d  = col_q + BB;
          addr_d = col_q + BB;
        end else begin
          wc_d   = '0;
          hc_d   = last_h ? '0 : hc_q + 1'b1;
          row_d  = row_q + lstr_q;
          col_d  = row_q + lstr_q;
          addr_d = row_q + lstr_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      sstr_q   <= '0;
      lstr_q   <= '0;
      c_q      <= '0;
      wc_q     <= '0;
      hc_q     <= '0;
      addr_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      wc_q     <= wc_d;
      hc_q     <= hc_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      credit_q <= pop;
      if (start_ok) begin
        ch_q   <= CH_in_div_Tout;
        w_q    <= w_in;
        h_q    <= h_in;
        sstr_q <= {6'd0, feature_out_surface_stride};
        lstr_q <= {16'd0, feature_out_line_stride};
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= dat_in;
  end

`ifdef LN_WDMA_OVF_CHK_EN
  logic ovf_q;
  assign ovf_err = ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          ovf_q <= 1'b0;
    else if (start_ok)                                   ovf_q <= 1'b0;
    else if (dat_in_vld && (!run || (full && !pop)))     ovf_q <= 1'b1;
  end
`endif

endmodule
